// File: rtl/spmv_pkg.sv
// Shared types and default widths for the SpMV row accumulator.
package spmv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } row_acc_state_e;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned ACC_W  = 48;
  localparam int unsigned ROW_W  = 16;

endpackage

// File: rtl/row_acc_add.sv
// Combinational sign-extend and add for the row accumulator.
// ROW_ACC_SAT_EN: when defined, the add saturates to the signed ACC_W range
// and flags ovf; otherwise it wraps and ovf stays 0.
module row_acc_add #(
  parameter int unsigned PROD_W = 32,
  parameter int unsigned ACC_W  = 48
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W-1:0] prod_ext;

  assign prod_ext = ACC_W'($signed(prod));

`ifdef ROW_ACC_SAT_EN
  logic [ACC_W:0] wide;

  assign wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};

  // Clamp to the signed extreme when the two top bits of the wide sum disagree.
  always_comb begin
    sum = wide[ACC_W-1:0];
    ovf = 1'b0;
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      ovf = 1'b1;
      sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum = acc + prod_ext;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/row_accumulator.sv
// Row accumulator: pops a row nnz count from the row FIFO, sums that many
// signed products and emits the row sum with its row index.
// Optional saturation is enabled with the ROW_ACC_SAT_EN macro (see row_acc_add).
module row_accumulator #(
  parameter int unsigned FIFO_W = 32,
  parameter int unsigned LEN_W  = spmv_pkg::LEN_W,
  parameter int unsigned PROD_W = spmv_pkg::PROD_W,
  parameter int unsigned ACC_W  = spmv_pkg::ACC_W,
  parameter int unsigned ROW_W  = spmv_pkg::ROW_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [FIFO_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [ACC_W-1:0]  y_data,
  output logic [ROW_W-1:0]  y_row,
  output logic              y_ovf
);

  import spmv_pkg::*;

  row_acc_state_e   state;
  logic [LEN_W-1:0] rem;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ROW_W-1:0] row;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [LEN_W-1:0] len;
  logic             unused_fifo_bits;

  assign len              = fifo_data[LEN_W-1:0];
  assign unused_fifo_bits = ^fifo_data[FIFO_W-1:LEN_W];

  // Pop only while idle and the FIFO has an entry; held low during reset.
  assign fifo_rd_en = !reset && (state == IDLE) && !fifo_empty;

  row_acc_add #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc (acc),
    .prod(prod_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Row FSM; prod_ready and y_valid are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rem        <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
      row        <= '0;
      prod_ready <= 1'b0;
      y_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_rd_en) begin
            acc <= '0;
            ovf <= 1'b0;
            if (len == '0) begin
              state   <= EMIT;
              y_valid <= 1'b1;
            end else begin
              rem        <= len;
              state      <= ACCUM;
              prod_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (prod_valid && prod_ready) begin
            acc <= add_sum;
            ovf <= ovf | add_ovf;
            rem <= rem - 1'b1;
            if (rem == LEN_W'(1)) begin
              state      <= EMIT;
              prod_ready <= 1'b0;
              y_valid    <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (y_ready) begin
            row     <= row + 1'b1;
            y_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          prod_ready <= 1'b0;
          y_valid    <= 1'b0;
        end
      endcase
    end
  end

  assign y_data = acc;
  assign y_row  = row;
  assign y_ovf  = ovf;

endmodule

// File: tb/tb_row_accumulator.sv
// Self-checking bench for row_accumulator: FIFO and product-stream models,
// a scoreboard of expected row results, and a narrow instance for wrap/saturate.
module tb_row_accumulator;

  localparam int unsigned AW = 48;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data = '0;
  logic        fifo_rd_en;
  logic        prod_valid = 1'b0;
  logic [31:0] prod_data = '0;
  logic        prod_ready;
  logic        y_valid;
  logic        y_ready = 1'b1;
  logic [AW-1:0] y_data;
  logic [15:0] y_row;
  logic        y_ovf;

  // Narrow instance signals (ACC_W = PROD_W = 8)
  logic        s_fifo_empty = 1'b1;
  logic [31:0] s_fifo_data = '0;
  logic        s_fifo_rd_en;
  logic        s_prod_valid = 1'b0;
  logic [7:0]  s_prod_data = '0;
  logic        s_prod_ready;
  logic        s_y_valid;
  logic        s_y_ready = 1'b0;
  logic [7:0]  s_y_data;
  logic [15:0] s_y_row;
  logic        s_y_ovf;

  typedef struct {
    logic [15:0]   row;
    logic [AW-1:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] fq[$];
  logic [31:0] pq[$];
  logic [15:0] exp_row = '0;
  int          vectors = 0;
  int          miscompares = 0;
  int          acc_cnt = 0;
  int unsigned cyc = 0;
  logic        toggle = 1'b0;

  always #5 clk = ~clk;

  row_accumulator dut (
    .clk(clk), .reset(reset),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_row(y_row), .y_ovf(y_ovf)
  );

  row_accumulator #(
    .FIFO_W(32), .LEN_W(16), .PROD_W(8), .ACC_W(8), .ROW_W(16)
  ) dut_narrow (
    .clk(clk), .reset(reset),
    .fifo_empty(s_fifo_empty), .fifo_data(s_fifo_data), .fifo_rd_en(s_fifo_rd_en),
    .prod_valid(s_prod_valid), .prod_data(s_prod_data), .prod_ready(s_prod_ready),
    .y_valid(s_y_valid), .y_ready(s_y_ready), .y_data(s_y_data), .y_row(s_y_row), .y_ovf(s_y_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_row(input logic [AW-1:0] d);
    exp_t e;
    e.row  = exp_row;
    e.data = d;
    sb.push_back(e);
    exp_row = exp_row + 16'd1;
  endtask

  // Upper bits of each FIFO entry carry junk that the DUT must ignore.
  task automatic push_len(input logic [15:0] len);
    fq.push_back({16'hABCD, len});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && fq.size() == 0 && pq.size() == 0) break;
    end
    check(tag, 64'(sb.size() + fq.size() + pq.size()), 64'd0);
  endtask

  // FIFO and product-source models: pop on handshakes, then drive the next heads.
  always @(posedge clk) begin
    logic [31:0] tmp;
    if (!reset && fifo_rd_en && fq.size() != 0) tmp = fq.pop_front();
    if (!reset && prod_valid && prod_ready && pq.size() != 0) begin
      tmp = pq.pop_front();
      acc_cnt++;
    end
    cyc++;
    #1;
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    prod_valid = (pq.size() != 0) && (!toggle || cyc[0]);
    prod_data  = (pq.size() != 0) ? pq[0] : '0;
  end

  // Result monitor: every accepted result must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && y_valid && y_ready) begin
      check("y_spurious", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("y_row", 64'(y_row), 64'(e.row));
        check("y_data", 64'(y_data), 64'(e.data));
        check("y_ovf", 64'(y_ovf), 64'd0);
      end
    end
  end

  initial begin
    int base;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_y_valid", 64'(y_valid), 64'd0);
    check("rst_prod_ready", 64'(prod_ready), 64'd0);
    check("rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_y_data", 64'(y_data), 64'd0);
    check("rst_y_row", 64'(y_row), 64'd0);
    check("rst_y_ovf", 64'(y_ovf), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Narrow instance: 100 + 100 in 8 bits
    s_fifo_empty = 1'b0;
    s_fifo_data  = 32'd2;
    @(posedge clk); #1;
    s_fifo_empty = 1'b1;
    s_prod_valid = 1'b1;
    s_prod_data  = 8'd100;
    @(posedge clk);
    @(posedge clk); #1;
    s_prod_valid = 1'b0;
    @(negedge clk);
    check("narrow_y_valid", 64'(s_y_valid), 64'd1);
    check("narrow_y_row", 64'(s_y_row), 64'd0);
`ifdef ROW_ACC_SAT_EN
    check("narrow_y_data", 64'(s_y_data), 64'h7F);
    check("narrow_y_ovf", 64'(s_y_ovf), 64'd1);
`else
    check("narrow_y_data", 64'(s_y_data), 64'hC8);
    check("narrow_y_ovf", 64'(s_y_ovf), 64'd0);
`endif
    @(posedge clk); #1 s_y_ready = 1'b1;
    @(posedge clk); #1 s_y_ready = 1'b0;
    @(negedge clk);
    check("narrow_y_done", 64'(s_y_valid), 64'd0);

    // Rows len 3,0,2
    push_len(16'd3); push_len(16'd0); push_len(16'd2);
    pq.push_back(32'd5); pq.push_back(-32'sd2); pq.push_back(32'd7);
    pq.push_back(32'd10); pq.push_back(32'd20);
    expect_row(48'd10); expect_row(48'd0); expect_row(48'd30);
    drain("drain_rows_302");

    // Back-pressure in EMIT with another row waiting in the FIFO
    y_ready = 1'b0;
    push_len(16'd2); push_len(16'd1);
    pq.push_back(32'd1); pq.push_back(32'd2); pq.push_back(32'd4);
    expect_row(48'd3); expect_row(48'd4);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (y_valid) break;
    end
    check("stall_reach_emit", 64'(y_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_y_valid", 64'(y_valid), 64'd1);
      check("stall_prod_ready", 64'(prod_ready), 64'd0);
      check("stall_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
      check("stall_y_data", 64'(y_data), 64'd3);
    end
    @(posedge clk); #1 y_ready = 1'b1;
    drain("drain_stall");

    // Gappy product stream on a len=4 row followed by a len=1 row
    toggle = 1'b1;
    base = acc_cnt;
    push_len(16'd4); push_len(16'd1);
    pq.push_back(-32'sd7); pq.push_back(32'd3); pq.push_back(-32'sd100);
    pq.push_back(32'd50); pq.push_back(32'd1000);
    expect_row(-48'sd54); expect_row(48'd1000);
    drain("drain_toggle");
    check("toggle_accepts", 64'(acc_cnt - base), 64'd5);
    toggle = 1'b0;

    // Reset after 2 of 3 products: aborted row never emits, row index restarts
    base = acc_cnt;
    push_len(16'd3);
    pq.push_back(32'd11); pq.push_back(32'd22);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_cnt - base >= 2) break;
    end
    check("abort_two_accepted", 64'(acc_cnt - base), 64'd2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_y_valid", 64'(y_valid), 64'd0);
    check("abort_prod_ready", 64'(prod_ready), 64'd0);
    check("abort_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
    check("abort_y_data", 64'(y_data), 64'd0);
    check("abort_y_row", 64'(y_row), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    exp_row = '0;
    push_len(16'd1);
    pq.push_back(32'd9);
    expect_row(48'd9);
    drain("drain_after_abort");

    // Empty FIFO: never pops, never takes products, never emits
    pq.push_back(32'd77);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("empty_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
      check("empty_prod_ready", 64'(prod_ready), 64'd0);
      check("empty_y_valid", 64'(y_valid), 64'd0);
    end
    check("empty_prod_kept", 64'(pq.size()), 64'd1);
    pq.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
